packed_pixel_unpacker: RTL and testbench
========================================

Name: packed_pixel_unpacker

Overview:
- Read-side counterpart of the 8-pixel shift packer on the SDRAM write port.
- Pulls packed bytes from an SDRAM read FIFO port, bits [7:0] of the 16-bit word.
- Expands each byte back into 8 one-bit pixels, one per VGA_Controller pixel request.
- Drives each pixel onto the 10-bit iRed/iGreen/iBlue inputs as all-ones or all-zeros, and tracks frame position.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- MSB_FIRST, 1, emit bit 7 first; the packer shifts new pixels into the LSB, so bit 7 is the oldest. 0 = bit 0 first.

Ports:
- iCLK  in  1  pixel clock, same clock as the VGA controller and the FIFO read clock.
- iRST_N  in  1  asynchronous active-low reset.
- iFRAME_START  in  1  one-cycle pulse at frame boundary; flushes and resynchronises.
- iREQ  in  1  pixel request (VGA oRequest), one pixel per high cycle.
- iFIFO_DATA  in  16  read FIFO data; only [7:0] used; valid the cycle after oFIFO_RD.
- iFIFO_EMPTY  in  1  read FIFO has no word.
- oFIFO_RD  out  1  one-cycle read strobe.
- oPIXEL  out  10  10'h3FF for pixel 1, 10'h000 for pixel 0.
- oPIX_VAL  out  1  oPIXEL updated this cycle.
- oX  out  10  column of the last emitted pixel.
- oY  out  9  line of the last emitted pixel.
- oFRAME_DONE  out  1  pulse after pixel (H_ACTIVE-1, V_ACTIVE-1) is emitted.
- oUNDERFLOW  out  1  sticky: a request arrived with no data.

Behaviour:
- Reset values: all outputs 0. Internal state after reset: cur and nxt buffers invalid, bit index at the first bit (7 if MSB_FIRST), state S_EMPTY.
- Storage:
  - cur[7:0] is the byte being shifted out; nxt[7:0] is the prefetch byte; each has a valid flag.
  - rd_pend marks a read issued last cycle.
- Prefetch rule: oFIFO_RD=1 for one cycle when all of these hold: nxt invalid, rd_pend=0, iFIFO_EMPTY=0, iFRAME_START=0.
  - On the cycle after the strobe, iFIFO_DATA[7:0] is captured into nxt, which becomes valid.
  - If cur is invalid at capture, the byte goes straight into cur instead.
  - At most one read is outstanding.
- States:
  - S_EMPTY: cur invalid. Goes to S_RUN when cur loads.
  - S_RUN: cur valid. On iREQ: oPIXEL is registered from cur[bit index], oPIX_VAL=1 the next cycle, and the bit index advances.
    - After the 8th bit, cur is replaced by nxt in the same cycle if nxt is valid, and nxt is invalidated. Otherwise go to S_EMPTY.
- Latency: one cycle from iREQ to oPIXEL/oPIX_VAL. Back-to-back requests every cycle are sustained with no bubbles, provided the FIFO is non-empty.
- Underflow: iREQ in S_EMPTY gives oPIXEL=0 and oPIX_VAL=1, and sets oUNDERFLOW.
  - The bit index does not advance; the lost slot is not re-consumed.
  - oX/oY still advance.
- Simultaneous events:
  - nxt capture and the 8th-bit consumption in the same cycle: the captured byte goes directly to cur.
  - iREQ in the same cycle cur first loads from S_EMPTY: treated as underflow; the new byte is kept intact.
- Counters:
  - oX/oY update with each emitted pixel: first pixel (0,0); oX wraps at H_ACTIVE-1 and increments oY.
  - After (H_ACTIVE-1, V_ACTIVE-1): oFRAME_DONE=1 for one cycle coincident with that oPIX_VAL, then counters wrap to (0,0) and streaming continues.
- iFRAME_START, which takes priority over every other action that cycle:
  - Invalidates cur, nxt and rd_pend; any in-flight FIFO data is dropped.
  - Resets the bit index and sets the counters so the next pixel is (0,0).
  - Clears oUNDERFLOW; suppresses oFIFO_RD that cycle.
  - A simultaneous iREQ is ignored (oPIX_VAL=0 next cycle).
- Reset asserted mid-frame: immediate return to reset values, independent of iCLK.
- Widths: oX 10 bits and oY 9 bits, sized for the 640x480 defaults. Bits [15:8] of iFIFO_DATA are ignored.

Test Plan:
- Reset, FIFO holds 8'hA5 then 8'h0F, iREQ held high 16 cycles: oFIFO_RD pulses twice; oPIXEL sequence 3FF,0,3FF,0,0,3FF,0,3FF,0,0,0,0,3FF,3FF,3FF,3FF; oPIX_VAL continuous; oUNDERFLOW=0.
- MSB_FIRST=0 with byte 8'h01: first oPIXEL 3FF, next seven 0.
- iFIFO_EMPTY=1 while iREQ pulses 3 times: three oPIX_VAL with oPIXEL=0; oUNDERFLOW=1; oX=2; no oFIFO_RD. Then supply 8'hFF: next request yields 3FF.
- Stream 38400 bytes of 8'hFF with continuous iREQ: oFRAME_DONE pulses exactly once, with oX=639 and oY=479; the next pixel reports (0,0).
- iFRAME_START mid-byte after 3 bits, with an outstanding read: the pending byte is dropped; the next byte starts at bit 7; counters restart at (0,0); oUNDERFLOW clears.
- Assert iRST_N low asynchronously mid-stream between clock edges: outputs go 0 immediately; after release, the first pixel comes from the first new FIFO byte.

Source files
------------

// File: rtl/packed_pixel_unpacker.sv
// packed_pixel_unpacker
// Read-side partner of the 8-pixel shift packer. It pulls packed bytes from
// an SDRAM read FIFO, expands each byte into eight 1-bit pixels (one per VGA
// request), drives them as full-scale or zero 10-bit colour values, and
// tracks the frame position of every emitted pixel.
module packed_pixel_unpacker #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFRAME_START,
    input  logic        iREQ,
    input  logic [15:0] iFIFO_DATA,
    input  logic        iFIFO_EMPTY,
    output logic        oFIFO_RD,
    output logic [9:0]  oPIXEL,
    output logic        oPIX_VAL,
    output logic [9:0]  oX,
    output logic [8:0]  oY,
    output logic        oFRAME_DONE,
    output logic        oUNDERFLOW
);

    localparam logic [2:0] FIRST_BIT = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] LAST_BIT  = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [9:0] X_LAST    = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST    = 9'(V_ACTIVE - 1);

    // S_EMPTY doubles as "cur invalid", S_RUN as "cur valid".
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cur_q, cur_d;
    logic [7:0]  nxt_q, nxt_d;
    logic        nxt_vld_q, nxt_vld_d;
    logic        rd_pend_q, rd_pend_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [9:0]  x_next_q, x_next_d;
    logic [8:0]  y_next_q, y_next_d;
    logic [9:0]  pixel_q, pixel_d;
    logic        pix_val_q, pix_val_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        frame_done_q, frame_done_d;
    logic        underflow_q, underflow_d;

    logic        rd_issue;
    logic        byte_done;
    logic        unused_fifo_hi;

    // Only the low byte carries packed pixels.
    assign unused_fifo_hi = ^iFIFO_DATA[15:8];

    // Prefetch whenever the spare slot is free and nothing is in flight; the
    // strobe is held low while reset is asserted so the FIFO is never popped.
    assign rd_issue = !nxt_vld_q && !rd_pend_q && !iFIFO_EMPTY && !iFRAME_START;
    assign oFIFO_RD = rd_issue && iRST_N;

    // Next-state logic: frame resync, pixel emission, byte refill and capture.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        nxt_d        = nxt_q;
        nxt_vld_d    = nxt_vld_q;
        rd_pend_d    = rd_issue;
        bit_idx_d    = bit_idx_q;
        x_next_d     = x_next_q;
        y_next_d     = y_next_q;
        pixel_d      = pixel_q;
        pix_val_d    = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        underflow_d  = underflow_q;
        byte_done    = 1'b0;

        if (iFRAME_START) begin
            state_d     = S_EMPTY;
            nxt_vld_d   = 1'b0;
            rd_pend_d   = 1'b0;
            bit_idx_d   = FIRST_BIT;
            x_next_d    = '0;
            y_next_d    = '0;
            underflow_d = 1'b0;
        end else begin
            if (iREQ) begin
                pix_val_d = 1'b1;
                if (state_q == S_RUN) begin
                    pixel_d = {10{cur_q[bit_idx_q]}};
                    if (bit_idx_q == LAST_BIT) begin
                        byte_done = 1'b1;
                        bit_idx_d = FIRST_BIT;
                    end else if (MSB_FIRST) begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    // Starved slot: emit black and leave the bit index alone.
                    pixel_d     = '0;
                    underflow_d = 1'b1;
                end

                x_d          = x_next_q;
                y_d          = y_next_q;
                frame_done_d = (x_next_q == X_LAST) && (y_next_q == Y_LAST);
                if (x_next_q == X_LAST) begin
                    x_next_d = '0;
                    y_next_d = (y_next_q == Y_LAST) ? 9'd0 : y_next_q + 9'd1;
                end else begin
                    x_next_d = x_next_q + 10'd1;
                end
            end

            if (byte_done) begin
                if (nxt_vld_q) begin
                    cur_d     = nxt_q;
                    nxt_vld_d = 1'b0;
                end else begin
                    state_d = S_EMPTY;
                end
            end

            // A read in flight implies nxt was empty, so the byte lands in
            // cur whenever cur is (or is just becoming) empty.
            if (rd_pend_q) begin
                if ((state_q == S_EMPTY) || (byte_done && !nxt_vld_q)) begin
                    cur_d   = iFIFO_DATA[7:0];
                    state_d = S_RUN;
                end else begin
                    nxt_d     = iFIFO_DATA[7:0];
                    nxt_vld_d = 1'b1;
                end
            end
        end
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_EMPTY;
            cur_q        <= '0;
            nxt_q        <= '0;
            nxt_vld_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            bit_idx_q    <= FIRST_BIT;
            x_next_q     <= '0;
            y_next_q     <= '0;
            pixel_q      <= '0;
            pix_val_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            nxt_q        <= nxt_d;
            nxt_vld_q    <= nxt_vld_d;
            rd_pend_q    <= rd_pend_d;
            bit_idx_q    <= bit_idx_d;
            x_next_q     <= x_next_d;
            y_next_q     <= y_next_d;
            pixel_q      <= pixel_d;
            pix_val_q    <= pix_val_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            underflow_q  <= underflow_d;
        end
    end

    assign oPIXEL      = pixel_q;
    assign oPIX_VAL    = pix_val_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oFRAME_DONE = frame_done_q;
    assign oUNDERFLOW  = underflow_q;

endmodule

// File: tb/tb_packed_pixel_unpacker.sv
// Testbench for packed_pixel_unpacker. Three instances share one stimulus
// stream: the default MSB-first 640x480 unit, an LSB-first unit, and a
// 16x3 unit whose frame wraps quickly enough to observe end of frame.
module tb_packed_pixel_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        req = 1'b0;
    logic [15:0] fifo_data = 16'h0000;
    logic        fifo_empty;

    logic        fifo_rd;
    logic [9:0]  pixel;
    logic        pix_val;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        frame_done;
    logic        underflow;

    logic        l_fifo_rd, s_fifo_rd;
    logic [9:0]  l_pixel, s_pixel;
    logic        l_pix_val, s_pix_val;
    logic [9:0]  l_x, s_x;
    logic [8:0]  l_y, s_y;
    logic        l_frame_done, s_frame_done;
    logic        l_underflow, s_underflow;

    int vec_count = 0;
    int miscompares = 0;
    int rd_count = 0;

    // Simple FIFO model: a small byte store, or an endless stream of 8'hFF.
    logic [7:0] fifo_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    bit         ff_stream = 1'b0;

    always #5 clk = ~clk;

    assign fifo_empty = ff_stream ? 1'b0 : (wr_ptr == rd_ptr);

    // Pops a byte on each strobe; it is visible on the bus the next cycle.
    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_count = rd_count + 1;
            if (ff_stream) begin
                fifo_data <= 16'h5AFF;
            end else begin
                fifo_data <= {8'h5A, fifo_mem[rd_ptr % 16]};
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    packed_pixel_unpacker dut (
        .iCLK(clk), .iRST_N(rst_n), .iFRAME_START(frame_start), .iREQ(req),
        .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty), .oFIFO_RD(fifo_rd),
        .oPIXEL(pixel), .oPIX_VAL(pix_val), .oX(x), .oY(y),
        .oFRAME_DONE(frame_done), .oUNDERFLOW(underflow)
    );

    packed_pixel_unpacker #(.MSB_FIRST(1'b0)) dut_lsb (
        .iCLK(clk), .iRST_N(rst_n), .iFRAME_START(frame_start), .iREQ(req),
        .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty), .oFIFO_RD(l_fifo_rd),
        .oPIXEL(l_pixel), .oPIX_VAL(l_pix_val), .oX(l_x), .oY(l_y),
        .oFRAME_DONE(l_frame_done), .oUNDERFLOW(l_underflow)
    );

    packed_pixel_unpacker #(.H_ACTIVE(16), .V_ACTIVE(3)) dut_small (
        .iCLK(clk), .iRST_N(rst_n), .iFRAME_START(frame_start), .iREQ(req),
        .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty), .oFIFO_RD(s_fifo_rd),
        .oPIXEL(s_pixel), .oPIX_VAL(s_pix_val), .oX(s_x), .oY(s_y),
        .oFRAME_DONE(s_frame_done), .oUNDERFLOW(s_underflow)
    );

    typedef struct {
        logic       req;
        logic [9:0] exp_msb;
        logic [9:0] exp_lsb;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic fs);
        req         = r;
        frame_start = fs;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count = vec_count + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] msb_bits;
        logic [15:0] lsb_bits;
        int          fd_pulses;
        logic [9:0]  fd_x;
        logic [8:0]  fd_y;
        int          val_count;

        // A5 then 0F; LSB-first A5 reads the same, 0F comes out reversed.
        msb_bits = 16'b1010_0101_0000_1111;
        lsb_bits = 16'b1010_0101_1111_0000;
        for (int i = 0; i < 16; i++) begin
            vecs[i].req     = 1'b1;
            vecs[i].exp_msb = msb_bits[15 - i] ? 10'h3FF : 10'h000;
            vecs[i].exp_lsb = lsb_bits[15 - i] ? 10'h3FF : 10'h000;
        end

        $display("[TB] reset state");
        pushByte(8'hA5);
        pushByte(8'h0F);
        #12;
        checkOutput("reset_pixel", 32'(pixel), 32'h0);
        checkOutput("reset_pix_val", 32'(pix_val), 32'h0);
        checkOutput("reset_x", 32'(x), 32'h0);
        checkOutput("reset_y", 32'(y), 32'h0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'h0);
        checkOutput("reset_underflow", 32'(underflow), 32'h0);
        checkOutput("reset_fifo_rd", 32'(fifo_rd), 32'h0);
        tick();
        rst_n = 1'b1;

        $display("[TB] A5/0F stream");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("prefetch_reads", 32'(rd_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, 1'b0);
            checkOutput($sformatf("a5_0f_val[%0d]", i), 32'(pix_val), 32'h1);
            checkOutput($sformatf("a5_0f_msb[%0d]", i), 32'(pixel), 32'(vecs[i].exp_msb));
            checkOutput($sformatf("a5_0f_lsb[%0d]", i), 32'(l_pixel), 32'(vecs[i].exp_lsb));
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("a5_0f_idle_val", 32'(pix_val), 32'h0);
        checkOutput("a5_0f_underflow", 32'(underflow), 32'h0);
        checkOutput("a5_0f_last_x", 32'(x), 32'd15);
        checkOutput("a5_0f_reads", 32'(rd_count), 32'd2);

        $display("[TB] byte 01 in both bit orders");
        pushByte(8'h01);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("b01_msb[%0d]", i), 32'(pixel), (i == 7) ? 32'h3FF : 32'h0);
            checkOutput($sformatf("b01_lsb[%0d]", i), 32'(l_pixel), (i == 0) ? 32'h3FF : 32'h0);
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("b01_last_x", 32'(x), 32'd23);
        checkOutput("b01_reads", 32'(rd_count), 32'd3);

        $display("[TB] underflow on empty FIFO");
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("uf_val[%0d]", i), 32'(pix_val), 32'h1);
            checkOutput($sformatf("uf_pixel[%0d]", i), 32'(pixel), 32'h0);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("uf_flag", 32'(underflow), 32'h1);
        checkOutput("uf_x", 32'(x), 32'd2);
        checkOutput("uf_y", 32'(y), 32'd0);
        checkOutput("uf_no_read", 32'(rd_count), 32'd3);
        pushByte(8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("uf_recover[%0d]", i), 32'(pixel), 32'h3FF);
        end
        checkOutput("uf_recover_x", 32'(x), 32'd5);

        $display("[TB] frame start mid-byte with a read in flight");
        req = 1'b0;
        pushByte(8'h0F);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("fs_req_ignored", 32'(pix_val), 32'h0);
        checkOutput("fs_underflow_clr", 32'(underflow), 32'h0);
        pushByte(8'h81);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("fs_pixel[%0d]", i), 32'(pixel),
                        (i == 0 || i == 7) ? 32'h3FF : 32'h0);
            if (i == 0) begin
                checkOutput("fs_first_x", 32'(x), 32'd0);
                checkOutput("fs_first_y", 32'(y), 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("fs_reads", 32'(rd_count), 32'd6);

        $display("[TB] frame wrap on 16x3 unit");
        applyStimulus(1'b0, 1'b1);
        ff_stream = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        fd_pulses = 0;
        fd_x      = '0;
        fd_y      = '0;
        val_count = 0;
        for (int i = 0; i < 49; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (pix_val) val_count = val_count + 1;
            if (s_frame_done) begin
                fd_pulses = fd_pulses + 1;
                fd_x      = s_x;
                fd_y      = s_y;
            end
        end
        checkOutput("wrap_pulses", 32'(fd_pulses), 32'd1);
        checkOutput("wrap_done_x", 32'(fd_x), 32'd15);
        checkOutput("wrap_done_y", 32'(fd_y), 32'd2);
        checkOutput("wrap_next_x", 32'(s_x), 32'd0);
        checkOutput("wrap_next_y", 32'(s_y), 32'd0);
        checkOutput("stream_no_bubble", 32'(val_count), 32'd49);
        checkOutput("stream_underflow", 32'(underflow), 32'h0);
        checkOutput("stream_main_x", 32'(x), 32'd48);

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_pixel", 32'(pixel), 32'h0);
        checkOutput("arst_pix_val", 32'(pix_val), 32'h0);
        checkOutput("arst_x", 32'(x), 32'h0);
        checkOutput("arst_fifo_rd", 32'(fifo_rd), 32'h0);
        ff_stream = 1'b0;
        req       = 1'b0;
        pushByte(8'h80);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("arst_first_pixel", 32'(pixel), 32'h3FF);
        checkOutput("arst_first_x", 32'(x), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("arst_second_pixel", 32'(pixel), 32'h0);
        applyStimulus(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
